// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int BE_WIDTH       = 4;
    localparam int BYTE_WIDTH     = 8;
    localparam int WAIT_CNT_WIDTH = 4;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - byte-enabled word array, synchronous write, combinational read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int SIZE_LAU   = 1024,
    parameter int DATA_WIDTH = 32,
    localparam int IDX_WIDTH = $clog2(SIZE_LAU) - 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic [BE_WIDTH-1:0]   be,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = SIZE_LAU / 4;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Update only the enabled byte lanes of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (be[b]) begin
                    mem[idx][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - req/gnt/rvalid memory responder; wait states under DMEM_WAIT_STATES_EN
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int SIZE_LAU    = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    localparam int IDX_WIDTH = $clog2(SIZE_LAU) - 2;
    localparam logic [ADDR_WIDTH-1:0] SIZE_ADDR = ADDR_WIDTH'(SIZE_LAU);

    dmem_state_e           state;
    dmem_state_e           state_next;
    logic                  out_of_range;
    logic                  arr_we;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    assign out_of_range = (addr_i >= SIZE_ADDR);

    // The array is written at the grant edge, so a read granted next cycle sees it
    assign arr_we = gnt_o & we_i & ~out_of_range;

    dmem_array #(
        .SIZE_LAU   (SIZE_LAU),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (addr_i[$clog2(SIZE_LAU)-1:2]),
        .be    (be_i),
        .wdata (wdata_i),
        .rdata (arr_rdata)
    );

`ifdef DMEM_WAIT_STATES_EN
    localparam bit USE_WAIT = (WAIT_CYCLES != 0);

    logic [WAIT_CNT_WIDTH-1:0] cnt;

    // Wait counter: load on a new request, count down while waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE, RESP: if (req_i && USE_WAIT) cnt <= WAIT_CNT_WIDTH'(WAIT_CYCLES - 1);
                WAIT:       if (cnt != '0) cnt <= cnt - 1'b1;
                default:    cnt <= '0;
            endcase
        end
    end
`else
    logic unused_wait_cfg;
    assign unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, RESP: begin
                if (!req_i) begin
                    state_next = IDLE;
                end else begin
`ifdef DMEM_WAIT_STATES_EN
                    state_next = USE_WAIT ? WAIT : RESP;
`else
                    state_next = RESP;
`endif
                end
            end
            WAIT: begin
`ifdef DMEM_WAIT_STATES_EN
                if (!req_i)          state_next = IDLE;
                else if (cnt == '0)  state_next = RESP;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant and response outputs; everything held low while in reset
    always_comb begin
        gnt_o    = 1'b0;
        rvalid_o = 1'b0;
        rdata_o  = '0;
        err_o    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE, RESP: begin
`ifdef DMEM_WAIT_STATES_EN
                    gnt_o = req_i & ~USE_WAIT;
`else
                    gnt_o = req_i;
`endif
                end
                WAIT: begin
`ifdef DMEM_WAIT_STATES_EN
                    gnt_o = req_i & (cnt == '0);
`else
                    gnt_o = 1'b0;
`endif
                end
                default: gnt_o = 1'b0;
            endcase
            rvalid_o = (state == RESP);
            rdata_o  = rdata_q;
            err_o    = err_q;
        end
    end

    // Response registers capture the granted access; cleared otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q   <= gnt_o & out_of_range;
            rdata_q <= (gnt_o & ~we_i & ~out_of_range) ? arr_rdata : '0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

`ifdef DMEM_WAIT_STATES_EN
    localparam int EXP_LAT = 3;
`else
    localparam int EXP_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic        req0, req3;
    logic        gnt0, rvalid0, err0;
    logic        gnt3, rvalid3, err3;
    logic [31:0] rdata0, rdata3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SIZE_LAU(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_i(req0), .gnt_o(gnt0), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0)
    );

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SIZE_LAU(1024), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req_i(req3), .gnt_o(gnt3), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic acc0(input string tag, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
        @(posedge clk); #1;
        we = w; addr = a; be = b; wdata = d; req0 = 1'b1;
        @(negedge clk);
        chk({tag, ".gnt"}, gnt0, 1);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        chk({tag, ".rvalid"}, rvalid0, 1);
        chk({tag, ".rdata"}, rdata0, exp_rd);
        chk({tag, ".err"}, err0, exp_err);
        @(negedge clk);
        chk({tag, ".rvalid_drop"}, rvalid0, 0);
    endtask

    task automatic acc3(input string tag, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] exp_rd);
        int lat;
        @(posedge clk); #1;
        we = w; addr = a; be = b; wdata = d; req3 = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!gnt3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".gnt"}, gnt3, 1);
        chk({tag, ".latency"}, lat, EXP_LAT);
        @(posedge clk); #1;
        req3 = 1'b0;
        @(negedge clk);
        chk({tag, ".rvalid"}, rvalid3, 1);
        chk({tag, ".rdata"}, rdata3, exp_rd);
        @(negedge clk);
        chk({tag, ".rvalid_drop"}, rvalid3, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_b2b [4];
        exp_b2b = '{32'h01020304, 32'h11223344, 32'h55667788, 32'h99AABBCC};

        // reset with requests pending: nothing may be granted or returned
        rst = 1'b1; req0 = 1'b1; req3 = 1'b1;
        we = 1'b1; addr = 32'h10; be = 4'hF; wdata = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.gnt0", gnt0, 0);
        chk("reset.rvalid0", rvalid0, 0);
        chk("reset.rdata0", rdata0, 0);
        chk("reset.err0", err0, 0);
        chk("reset.gnt3", gnt3, 0);
        chk("reset.rvalid3", rvalid3, 0);
        @(posedge clk); #1;
        rst = 1'b0; req0 = 1'b0; req3 = 1'b0;

        // word, byte, halfword writes and readback
        acc0("wr_word",  1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0);
        acc0("rd_word",  1'b0, 32'h10, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0);
        acc0("wr_byte",  1'b1, 32'h10, 4'h1, 32'h12345655, 32'h0,        1'b0);
        acc0("rd_byte",  1'b0, 32'h10, 4'h0, 32'h0,        32'hDEADBE55, 1'b0);
        acc0("wr_half",  1'b1, 32'h10, 4'hC, 32'hABCD7777, 32'h0,        1'b0);
        acc0("rd_half",  1'b0, 32'h10, 4'hF, 32'h0,        32'hABCDBE55, 1'b0);
        acc0("wr_be0",   1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0);
        acc0("rd_be0",   1'b0, 32'h10, 4'hF, 32'h0,        32'hABCDBE55, 1'b0);

        // out-of-range accesses must not alias onto word 0
        acc0("wr_w0",    1'b1, 32'h0,   4'hF, 32'h01020304, 32'h0,        1'b0);
        acc0("rd_oob",   1'b0, 32'h400, 4'hF, 32'h0,        32'h0,        1'b1);
        acc0("wr_oob",   1'b1, 32'h400, 4'hF, 32'h11111111, 32'h0,        1'b1);
        acc0("rd_w0",    1'b0, 32'h0,   4'hF, 32'h0,        32'h01020304, 1'b0);
        acc0("wr_top",   1'b1, 32'h3FC, 4'hF, 32'h0BADF00D, 32'h0,        1'b0);
        acc0("rd_top",   1'b0, 32'h3FC, 4'hF, 32'h0,        32'h0BADF00D, 1'b0);

        // back-to-back reads: one grant per cycle, responses in order
        acc0("wr_w1", 1'b1, 32'h4, 4'hF, 32'h11223344, 32'h0, 1'b0);
        acc0("wr_w2", 1'b1, 32'h8, 4'hF, 32'h55667788, 32'h0, 1'b0);
        acc0("wr_w3", 1'b1, 32'hC, 4'hF, 32'h99AABBCC, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i < 4) begin
                req0 = 1'b1; we = 1'b0; be = 4'hF; addr = 32'(i * 4);
            end else begin
                req0 = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("b2b%0d.gnt", i), gnt0, (i < 4) ? 32'd1 : 32'd0);
            chk($sformatf("b2b%0d.rvalid", i), rvalid0, (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) chk($sformatf("b2b%0d.rdata", i), rdata0, exp_b2b[i-1]);
        end

        // wait-state instance
        acc3("w3_wr", 1'b1, 32'h20, 4'hF, 32'h5A5A5A5A, 32'h0);
        acc3("w3_rd", 1'b0, 32'h20, 4'hF, 32'h0,        32'h5A5A5A5A);

        // reset while a write is waiting: it must be dropped
        @(posedge clk); #1;
        we = 1'b1; addr = 32'h20; be = 4'hF; wdata = 32'hFFFFFFFF;
`ifdef DMEM_WAIT_STATES_EN
        req3 = 1'b1;
        @(negedge clk);
        chk("rstw.gnt_c0", gnt3, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw.gnt_c1", gnt3, 0);
        @(posedge clk); #1;
        rst = 1'b1;
`else
        rst = 1'b1; req3 = 1'b1;
`endif
        @(negedge clk);
        chk("rstw.gnt_rst", gnt3, 0);
        chk("rstw.rvalid_rst", rvalid3, 0);
        @(posedge clk); #1;
        rst = 1'b0; req3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rstw%0d.gnt", i), gnt3, 0);
            chk($sformatf("rstw%0d.rvalid", i), rvalid3, 0);
        end
        acc3("w3_reread", 1'b0, 32'h20, 4'hF, 32'h0, 32'h5A5A5A5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
